adc_conv_sequencer: RTL



---
 rtl/adc_conv_sequencer.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/adc_conv_sequencer.sv
// Conversion sequencer for a parallel 16-bit ADC with active-low CONVST/CS/RD
// strobes and an active-low EOC. It issues periodic conversion starts, waits
// for end-of-conversion, strobes the read, latches the data bus and produces
// raw samples plus a 2^AVG_LOG2 boxcar average. It also handles EOC timeout,
// trigger overrun and a shutdown/wake sequence.
module adc_conv_sequencer #(
  parameter int DW          = 16,
  parameter int SAMPLE_DIV  = 5000,
  parameter int CONVST_LOW  = 4,
  parameter int RD_LOW      = 3,
  parameter int TIMEOUT     = 1000,
  parameter int WAKE_CYCLES = 200,
  parameter int AVG_LOG2    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          shdn_req,
  input  logic          clear_err,
  input  logic          eoc_n,
  input  logic [DW-1:0] db,
  output logic          convst_n,
  output logic          cs_n,
  output logic          rd_n,
  output logic          wr_n,
  output logic          shdn,
  output logic [DW-1:0] sample,
  output logic          sample_valid,
  output logic [DW-1:0] avg_out,
  output logic          avg_valid,
  output logic          timeout_err,
  output logic          overrun_err,
  output logic          busy
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_CONV  = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_SHDN  = 3'd4;
  localparam logic [2:0] ST_WAKE  = 3'd5;

  // One shared phase counter serves START, CONV, READ and WAKE, so it is
  // sized for the longest of those phases.
  localparam int MAX_A = (CONVST_LOW > RD_LOW) ? CONVST_LOW : RD_LOW;
  localparam int MAX_B = (TIMEOUT > WAKE_CYCLES) ? TIMEOUT : WAKE_CYCLES;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNTW  = $clog2(MAX_C + 1);
  localparam int TMRW  = $clog2(SAMPLE_DIV);
  localparam int AW    = DW + AVG_LOG2;
  localparam int NW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [CNTW-1:0] CONVST_LAST = CNTW'(CONVST_LOW - 1);
  localparam logic [CNTW-1:0] RD_LAST     = CNTW'(RD_LOW - 1);
  localparam logic [CNTW-1:0] TO_LAST     = CNTW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] WAKE_LAST   = CNTW'(WAKE_CYCLES - 1);
  localparam logic [TMRW-1:0] TMR_LAST    = TMRW'(SAMPLE_DIV - 1);
  localparam logic [NW-1:0]   NUM_LAST    = NW'((1 << AVG_LOG2) - 1);

  logic            eoc_s1_q, eoc_s2_q, eoc_s3_q;
  logic            eoc_fall;
  logic [TMRW-1:0] timer_q, timer_d;
  logic            timer_run, tick;
  logic [2:0]      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            shdn_pend_q, shdn_pend_d;
  logic            shdn_any;
  logic            capture, to_evt, ovr_evt;
  logic            in_xfer;
  logic            convst_n_q, rd_n_q, shdn_q, busy_q;
  logic [DW-1:0]   sample_q, avg_q;
  logic            sample_valid_q, avg_valid_q;
  logic            timeout_q, overrun_q;
  logic [AW-1:0]   acc_q, acc_sum, acc_shift;
  logic [NW-1:0]   num_q;

  assign eoc_fall  = eoc_s3_q & ~eoc_s2_q;
  assign in_xfer   = (state_q == ST_START) || (state_q == ST_CONV) || (state_q == ST_READ);
  assign timer_run = enable && (state_q != ST_SHDN) && (state_q != ST_WAKE);
  assign tick      = timer_run && (timer_q == TMR_LAST);
  assign timer_d   = (timer_run && !tick) ? timer_q + 1'b1 : '0;
  assign ovr_evt   = tick && in_xfer;
  assign shdn_any  = shdn_req | shdn_pend_q;
  assign acc_sum   = acc_q + AW'(db);
  assign acc_shift = acc_sum >> AVG_LOG2;

  // Two-flop synchronizer for the asynchronous EOC plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eoc_s1_q <= 1'b1;
      eoc_s2_q <= 1'b1;
      eoc_s3_q <= 1'b1;
    end else begin
      eoc_s1_q <= eoc_n;
      eoc_s2_q <= eoc_s1_q;
      eoc_s3_q <= eoc_s2_q;
    end
  end

  // Free-running trigger timer; held at zero while disabled, shut down or waking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // Next-state logic for the conversion sequence and the shared phase counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shdn_pend_d = shdn_pend_q;
    capture     = 1'b0;
    to_evt      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (shdn_req) begin
          state_d = ST_SHDN;
        end else if (tick) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == CONVST_LAST) begin
          state_d = ST_CONV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CONV: begin
        if (eoc_fall) begin
          state_d = ST_READ;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          to_evt  = 1'b1;
          state_d = shdn_any ? ST_SHDN : ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READ: begin
        if (cnt_q == RD_LAST) begin
          capture = 1'b1;
          state_d = shdn_any ? ST_SHDN : ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHDN: begin
        cnt_d = '0;
        if (!shdn_req) begin
          state_d = ST_WAKE;
        end
      end
      ST_WAKE: begin
        if (shdn_req) begin
          state_d = ST_SHDN;
          cnt_d   = '0;
        end else if (cnt_q == WAKE_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // A shutdown request seen mid-transaction is remembered until the transaction ends.
    if (shdn_req && in_xfer) begin
      shdn_pend_d = 1'b1;
    end
    if (state_d == ST_SHDN) begin
      shdn_pend_d = 1'b0;
    end
  end

  // State, phase counter and pending-shutdown registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shdn_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shdn_pend_q <= shdn_pend_d;
    end
  end

  // ADC control pins decoded from the next state so they toggle glitch-free with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      convst_n_q <= 1'b1;
      rd_n_q     <= 1'b1;
      shdn_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      convst_n_q <= (state_d != ST_START);
      rd_n_q     <= (state_d != ST_READ);
      shdn_q     <= (state_d == ST_SHDN);
      busy_q     <= (state_d == ST_START) || (state_d == ST_CONV) || (state_d == ST_READ);
    end
  end

  // Capture the bus on the last read-low cycle and accumulate the boxcar average.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      avg_q          <= '0;
      avg_valid_q    <= 1'b0;
      acc_q          <= '0;
      num_q          <= '0;
    end else begin
      sample_valid_q <= capture;
      avg_valid_q    <= 1'b0;
      if (capture) begin
        sample_q <= db;
        if (num_q == NUM_LAST) begin
          avg_q       <= acc_shift[DW-1:0];
          avg_valid_q <= 1'b1;
          acc_q       <= '0;
          num_q       <= '0;
        end else begin
          acc_q <= acc_sum;
          num_q <= num_q + 1'b1;
        end
      end
    end
  end

  // Sticky error flags; a new event in the same cycle as clear_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (to_evt) begin
        timeout_q <= 1'b1;
      end else if (clear_err) begin
        timeout_q <= 1'b0;
      end
      if (ovr_evt) begin
        overrun_q <= 1'b1;
      end else if (clear_err) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign convst_n     = convst_n_q;
  assign cs_n         = rd_n_q;
  assign rd_n         = rd_n_q;
  assign wr_n         = 1'b1;
  assign shdn         = shdn_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign avg_out      = avg_q;
  assign avg_valid    = avg_valid_q;
  assign timeout_err  = timeout_q;
  assign overrun_err  = overrun_q;
  assign busy         = busy_q;

endmodule
